// File: rtl/cpu_for_diagram.sv
// Ball-balancer control core: Pixy UART frame receiver, two-axis PID, three-motor
// mixing, step/dir generation and seven-segment status display.
module cpu_for_diagram #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       clk_b,
  input  logic       pixy_in,
  input  logic       arduino_in,
  input  logic       sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8, sw9,
  input  logic       key_1, key_2, key_3,
  output logic       m1_step_out, m2_step_out, m3_step_out,
  output logic       m1_dir_out, m2_dir_out, m3_dir_out,
  output logic [0:6] Disp1, Disp2, Disp3, Disp4, Disp5, Disp6
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]      SyncByte = 8'hA5;
  localparam logic signed [15:0] IMax = 16'sd8191;
  localparam logic signed [15:0] IMin = -16'sd8191;
  localparam logic signed [15:0] UMax = 16'sd511;
  localparam logic signed [15:0] UMin = -16'sd511;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {PsSync, PsX, PsY} ps_state_e;

  // ---------------------------------------------------------------------------------------------
  logic [2:0] clk_b_q, key1_q, key3_q, rx_q;
  logic [1:0] key2_q, arm_q;

  // Two-flop synchronizers; edge-detected inputs keep a third stage as the previous value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_b_q <= '0;
      arm_q   <= '0;
      key1_q  <= '1;
      key2_q  <= '1;
      key3_q  <= '1;
      rx_q    <= '1;
    end else begin
      clk_b_q <= {clk_b_q[1:0], clk_b};
      arm_q   <= {arm_q[0], arduino_in};
      key1_q  <= {key1_q[1:0], key_1};
      key2_q  <= {key2_q[0], key_2};
      key3_q  <= {key3_q[1:0], key_3};
      rx_q    <= {rx_q[1:0], pixy_in};
    end
  end

  logic pid_edge, key1_fall, key3_fall, view_sp, armed, rx_bit, rx_fall;
  assign pid_edge  = clk_b_q[1] & ~clk_b_q[2];
  assign key1_fall = ~key1_q[1] & key1_q[2];
  assign key3_fall = ~key3_q[1] & key3_q[2];
  assign view_sp   = ~key2_q[1];
  assign armed     = arm_q[1];
  assign rx_bit    = rx_q[1];
  assign rx_fall   = ~rx_q[1] & rx_q[2];

  // ---------------------------------------------------------------------------------------------
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_valid, byte_err;

  // UART receiver state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // UART next state: a start is a falling edge, so a low line after a framing error is not
  // mistaken for a new start bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RxStart;
      end
      RxStart: if (rx_cnt_q == HalfLast) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_bit ? RxIdle : RxData;
      end
      RxData: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_bit, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 1'b1;
        if (rx_idx_q == 3'd7) rx_state_d = RxStop;
      end
      RxStop: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_state_d = RxIdle;
        byte_valid = rx_bit;
        byte_err   = ~rx_bit;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  ps_state_e ps_state_q, ps_state_d;
  logic      x_latch, commit;

  // Frame parser next state: sync, X, Y; a dropped byte restarts at sync.
  always_comb begin
    ps_state_d = ps_state_q;
    x_latch    = 1'b0;
    commit     = 1'b0;
    if (byte_err) begin
      ps_state_d = PsSync;
    end else if (byte_valid) begin
      case (ps_state_q)
        PsSync: if (rx_shift_q == SyncByte) ps_state_d = PsX;
        PsX: begin
          x_latch    = 1'b1;
          ps_state_d = PsY;
        end
        PsY: begin
          commit     = 1'b1;
          ps_state_d = PsSync;
        end
        default: ps_state_d = PsSync;
      endcase
    end
  end

  logic [7:0] x_tmp_q;
  logic [7:0] pos_q [2];
  logic [7:0] sp_q  [2];

  // Parser state, position commit and setpoint capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_state_q <= PsSync;
      x_tmp_q    <= '0;
      for (int a = 0; a < 2; a++) begin
        pos_q[a] <= 8'h80;
        sp_q[a]  <= 8'h80;
      end
    end else begin
      ps_state_q <= ps_state_d;
      if (x_latch) x_tmp_q <= rx_shift_q;
      if (commit) begin
        pos_q[0] <= x_tmp_q;
        pos_q[1] <= rx_shift_q;
      end
      if (key1_fall) begin
        sp_q[0] <= pos_q[0];
        sp_q[1] <= pos_q[1];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  logic [2:0] kp, ki, kd;
  assign kp = {sw3, sw2, sw1};
  assign ki = {sw6, sw5, sw4};
  assign kd = {sw9, sw8, sw7};

  logic signed [15:0] kp_s, ki_s, kd_s;
  assign kp_s = $signed({13'd0, kp});
  assign ki_s = $signed({13'd0, ki});
  assign kd_s = $signed({13'd0, kd});

  logic signed [15:0] e_w [2];
  logic signed [15:0] ep_w [2];
  logic signed [15:0] i_sum [2];
  logic signed [15:0] i_new [2];
  logic signed [15:0] u_sum [2];
  logic signed [10:0] u_new [2];
  logic signed [15:0] i_q [2];
  logic signed [10:0] u_q [2];
  logic signed [8:0]  e_prev_q [2];

  // PID arithmetic per axis; u uses the freshly clamped integrator.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      e_w[a]   = $signed({8'd0, sp_q[a]}) - $signed({8'd0, pos_q[a]});
      ep_w[a]  = $signed({{7{e_prev_q[a][8]}}, e_prev_q[a]});
      i_sum[a] = i_q[a] + ki_s * e_w[a];
      if (i_sum[a] > IMax)      i_new[a] = IMax;
      else if (i_sum[a] < IMin) i_new[a] = IMin;
      else                      i_new[a] = i_sum[a];
      u_sum[a] = kp_s * e_w[a] + (i_new[a] >>> 4) + kd_s * (e_w[a] - ep_w[a]);
      if (u_sum[a] > UMax)      u_new[a] = 11'sd511;
      else if (u_sum[a] < UMin) u_new[a] = -11'sd511;
      else                      u_new[a] = u_sum[a][10:0];
    end
  end

  logic signed [10:0] c_w;
  logic signed [10:0] t_q [3];
  assign c_w = u_q[0] - (u_q[0] >>> 3);

  // PID state update on the sample edge; key_3 clearing wins over an update. Targets trail u.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < 2; a++) begin
        i_q[a]      <= '0;
        u_q[a]      <= '0;
        e_prev_q[a] <= '0;
      end
      for (int m = 0; m < 3; m++) t_q[m] <= '0;
    end else begin
      for (int a = 0; a < 2; a++) begin
        if (key3_fall)     i_q[a] <= '0;
        else if (pid_edge) i_q[a] <= i_new[a];
        if (pid_edge) begin
          u_q[a]      <= u_new[a];
          e_prev_q[a] <= e_w[a][8:0];
        end
      end
      t_q[0] <= u_q[1];
      t_q[1] <= c_w - (u_q[1] >>> 1);
      t_q[2] <= -(u_q[1] >>> 1) - c_w;
    end
  end

  // ---------------------------------------------------------------------------------------------
  logic               step_q [3];
  logic               dir_q  [3];
  logic signed [10:0] p_q    [3];

  // Step generators: direction latched at step rise, position moves at step fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 3; m++) begin
        step_q[m] <= 1'b0;
        dir_q[m]  <= 1'b0;
        p_q[m]    <= '0;
      end
    end else if (clk_en) begin
      for (int m = 0; m < 3; m++) begin
        if (armed && (p_q[m] != t_q[m])) begin
          if (!step_q[m]) begin
            dir_q[m]  <= (t_q[m] > p_q[m]);
            step_q[m] <= 1'b1;
          end else begin
            step_q[m] <= 1'b0;
            p_q[m]    <= dir_q[m] ? p_q[m] + 11'sd1 : p_q[m] - 11'sd1;
          end
        end else begin
          step_q[m] <= 1'b0;
        end
      end
    end
  end

  assign m1_step_out = step_q[0];
  assign m2_step_out = step_q[1];
  assign m3_step_out = step_q[2];
  assign m1_dir_out  = dir_q[0];
  assign m2_dir_out  = dir_q[1];
  assign m3_dir_out  = dir_q[2];

  // ---------------------------------------------------------------------------------------------
  function automatic logic [0:6] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  logic [7:0] show_x, show_y;
  logic [0:6] disp_q [4];
  assign show_x = view_sp ? sp_q[0] : pos_q[0];
  assign show_y = view_sp ? sp_q[1] : pos_q[1];

  // Registered position/setpoint digits; reset shows "8080".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q[0] <= 7'b0000000;
      disp_q[1] <= 7'b0000001;
      disp_q[2] <= 7'b0000000;
      disp_q[3] <= 7'b0000001;
    end else begin
      disp_q[0] <= hex_seg(show_x[7:4]);
      disp_q[1] <= hex_seg(show_x[3:0]);
      disp_q[2] <= hex_seg(show_y[7:4]);
      disp_q[3] <= hex_seg(show_y[3:0]);
    end
  end

  assign Disp1 = disp_q[0];
  assign Disp2 = disp_q[1];
  assign Disp3 = disp_q[2];
  assign Disp4 = disp_q[3];
  assign Disp5 = hex_seg({1'b0, kp});
  assign Disp6 = hex_seg({1'b0, ki});

endmodule

// File: tb/tb_cpu_for_diagram.sv
// Directed bench for cpu_for_diagram: frames, keys, PID targets observed via step counts.
module tb_cpu_for_diagram;
  localparam int unsigned Cpb = 16;

  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0, clk_b = 1'b0;
  logic pixy_in = 1'b1, arduino_in = 1'b0;
  logic sw1 = 0, sw2 = 0, sw3 = 0, sw4 = 0, sw5 = 0, sw6 = 0, sw7 = 0, sw8 = 0, sw9 = 0;
  logic key_1 = 1'b1, key_2 = 1'b1, key_3 = 1'b1;
  logic m1_step_out, m2_step_out, m3_step_out, m1_dir_out, m2_dir_out, m3_dir_out;
  logic [0:6] disp1, disp2, disp3, disp4, disp5, disp6;

  int checks = 0;
  int failures = 0;
  int r1 = 0, r2 = 0, r3 = 0;
  logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;

  cpu_for_diagram #(.CLKS_PER_BIT(Cpb)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .clk_b(clk_b), .pixy_in(pixy_in),
    .arduino_in(arduino_in),
    .sw1(sw1), .sw2(sw2), .sw3(sw3), .sw4(sw4), .sw5(sw5), .sw6(sw6), .sw7(sw7), .sw8(sw8),
    .sw9(sw9), .key_1(key_1), .key_2(key_2), .key_3(key_3),
    .m1_step_out(m1_step_out), .m2_step_out(m2_step_out), .m3_step_out(m3_step_out),
    .m1_dir_out(m1_dir_out), .m2_dir_out(m2_dir_out), .m3_dir_out(m3_dir_out),
    .Disp1(disp1), .Disp2(disp2), .Disp3(disp3), .Disp4(disp4), .Disp5(disp5), .Disp6(disp6)
  );

  always #5 clk = ~clk;

  // Step-rise counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (m1_step_out && !p1) r1 <= r1 + 1;
    if (m2_step_out && !p2) r2 <= r2 + 1;
    if (m3_step_out && !p3) r3 <= r3 + 1;
    p1 <= m1_step_out;
    p2 <= m2_step_out;
    p3 <= m3_step_out;
  end

  function automatic logic [0:6] seg_ref(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [27:0] disp_ref(input logic [7:0] x, input logic [7:0] y);
    return {seg_ref(x[7:4]), seg_ref(x[3:0]), seg_ref(y[7:4]), seg_ref(y[3:0])};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_gains(input logic [2:0] kp, input logic [2:0] ki, input logic [2:0] kd);
    {sw3, sw2, sw1} = kp;
    {sw6, sw5, sw4} = ki;
    {sw9, sw8, sw7} = kd;
    wait_cyc(1);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    pixy_in = 1'b0;
    wait_cyc(Cpb);
    for (int i = 0; i < 8; i++) begin
      pixy_in = b[i];
      wait_cyc(Cpb);
    end
    pixy_in = stop;
    wait_cyc(Cpb);
    pixy_in = 1'b1;
    wait_cyc(2 * Cpb);
  endtask

  task automatic send_frame(input logic [7:0] x, input logic [7:0] y);
    send_bits(8'hA5, 1'b1);
    send_bits(x, 1'b1);
    send_bits(y, 1'b1);
    wait_cyc(3);
  endtask

  task automatic pulse_clk_b();
    clk_b = 1'b1;
    wait_cyc(4);
    clk_b = 1'b0;
    wait_cyc(6);
  endtask

  task automatic arm(input logic v);
    arduino_in = v;
    wait_cyc(4);
  endtask

  task automatic press_key(input int k);
    if (k == 1) key_1 = 1'b0; else if (k == 2) key_2 = 1'b0; else key_3 = 1'b0;
    wait_cyc(5);
    key_1 = 1'b1;
    key_2 = 1'b1;
    key_3 = 1'b1;
    wait_cyc(5);
  endtask

  task automatic tick(input int n, output int d1, output int d2, output int d3);
    int b1, b2, b3;
    b1 = r1; b2 = r2; b3 = r3;
    repeat (n) begin
      clk_en = 1'b1;
      wait_cyc(1);
      clk_en = 1'b0;
      wait_cyc(3);
    end
    d1 = r1 - b1; d2 = r2 - b2; d3 = r3 - b3;
  endtask

  task automatic test_reset(input logic [2:0] kp, input logic [2:0] ki);
    set_gains(kp, ki, 3'd0);
    reset = 1'b1;
    wait_cyc(3);
    checks++;
    if ({m1_step_out, m2_step_out, m3_step_out, m1_dir_out, m2_dir_out, m3_dir_out} !== 6'b0)
    begin
      failures++;
      $display("FAIL reset_pins got %b%b%b %b%b%b want 000 000", m1_step_out, m2_step_out,
               m3_step_out, m1_dir_out, m2_dir_out, m3_dir_out);
    end
    checks++;
    if ({disp1, disp2, disp3, disp4} !== disp_ref(8'h80, 8'h80)) begin
      failures++;
      $display("FAIL reset_disp got %b want %b", {disp1, disp2, disp3, disp4},
               disp_ref(8'h80, 8'h80));
    end
    checks++;
    if ({disp5, disp6} !== {seg_ref({1'b0, kp}), seg_ref({1'b0, ki})}) begin
      failures++;
      $display("FAIL reset_gain_disp got %b want %b", {disp5, disp6},
               {seg_ref({1'b0, kp}), seg_ref({1'b0, ki})});
    end
    reset = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_uart_frame();
    send_bits(8'h13, 1'b1);
    send_frame(8'h40, 8'hC0);
    checks++;
    if ({disp1, disp2, disp3, disp4} !== disp_ref(8'h40, 8'hC0)) begin
      failures++;
      $display("FAIL uart_frame got %b want %b", {disp1, disp2, disp3, disp4},
               disp_ref(8'h40, 8'hC0));
    end
    // Bad stop after sync restarts the parser, so 11/22 are not taken as X/Y.
    send_bits(8'hA5, 1'b1);
    send_bits(8'h5A, 1'b0);
    send_bits(8'h11, 1'b1);
    send_bits(8'h22, 1'b1);
    wait_cyc(3);
    checks++;
    if ({disp1, disp2, disp3, disp4} !== disp_ref(8'h40, 8'hC0)) begin
      failures++;
      $display("FAIL uart_bad_stop got %b want %b", {disp1, disp2, disp3, disp4},
               disp_ref(8'h40, 8'hC0));
    end
  endtask

  task automatic test_keys_view();
    key_2 = 1'b0;
    wait_cyc(4);
    checks++;
    if ({disp1, disp2, disp3, disp4} !== disp_ref(8'h80, 8'h80)) begin
      failures++;
      $display("FAIL key2_view_sp got %b want %b", {disp1, disp2, disp3, disp4},
               disp_ref(8'h80, 8'h80));
    end
    key_2 = 1'b1;
    press_key(1);
    key_2 = 1'b0;
    send_frame(8'h12, 8'h34);
    checks++;
    if ({disp1, disp2, disp3, disp4} !== disp_ref(8'h40, 8'hC0)) begin
      failures++;
      $display("FAIL key1_setpoint got %b want %b", {disp1, disp2, disp3, disp4},
               disp_ref(8'h40, 8'hC0));
    end
    key_2 = 1'b1;
    wait_cyc(4);
    checks++;
    if ({disp1, disp2, disp3, disp4} !== disp_ref(8'h12, 8'h34)) begin
      failures++;
      $display("FAIL key2_release got %b want %b", {disp1, disp2, disp3, disp4},
               disp_ref(8'h12, 8'h34));
    end
  endtask

  task automatic test_proportional();
    set_gains(3'd1, 3'd0, 3'd0);
    send_frame(8'h70, 8'h80);
    checks++;
    if ({disp1, disp2, disp3, disp4} !== disp_ref(8'h70, 8'h80)) begin
      failures++;
      $display("FAIL prop_pos got %b want %b", {disp1, disp2, disp3, disp4},
               disp_ref(8'h70, 8'h80));
    end
    pulse_clk_b();
  endtask

  // u_x = 16 gives T1 = 0, T2 = 14, T3 = -14.
  task automatic test_stepping();
    int d1, d2, d3;
    arm(1'b1);
    tick(28, d1, d2, d3);
    checks++;
    if ({d1, d2, d3} !== {32'd0, 32'd14, 32'd14}) begin
      failures++;
      $display("FAIL step_count got %0d/%0d/%0d want 0/14/14", d1, d2, d3);
    end
    checks++;
    if ({m2_dir_out, m3_dir_out} !== 2'b10) begin
      failures++;
      $display("FAIL step_dir got %b%b want 10", m2_dir_out, m3_dir_out);
    end
    tick(12, d1, d2, d3);
    checks++;
    if ({d1, d2, d3, m1_step_out, m2_step_out, m3_step_out} !== {32'd0, 32'd0, 32'd0, 3'b0})
    begin
      failures++;
      $display("FAIL step_idle got %0d/%0d/%0d want 0/0/0", d1, d2, d3);
    end
  endtask

  // u_x = 32 gives T2 = 28, T3 = -28: 14 more steps from 14/-14.
  task automatic test_disarm();
    int d1, d2, d3;
    arm(1'b0);
    send_frame(8'h60, 8'h80);
    pulse_clk_b();
    arm(1'b1);
    tick(10, d1, d2, d3);
    checks++;
    if ({d2, d3} !== {32'd5, 32'd5}) begin
      failures++;
      $display("FAIL disarm_pre got %0d/%0d want 5/5", d2, d3);
    end
    arm(1'b0);
    tick(10, d1, d2, d3);
    checks++;
    if ({d1, d2, d3} !== {32'd0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL disarm_hold got %0d/%0d/%0d want 0/0/0", d1, d2, d3);
    end
    arm(1'b1);
    tick(30, d1, d2, d3);
    checks++;
    if ({d2, d3, m2_dir_out} !== {32'd9, 32'd9, 1'b1}) begin
      failures++;
      $display("FAIL rearm got %0d/%0d dir %b want 9/9 dir 1", d2, d3, m2_dir_out);
    end
  endtask

  // 20 edges at e=100 saturate I at 8191; two at e=-100 give 6791, u=424, T2=371.
  task automatic test_integrator();
    int d1, d2, d3;
    arm(1'b0);
    set_gains(3'd0, 3'd7, 3'd0);
    checks++;
    if (disp6 !== 7'b0001111) begin
      failures++;
      $display("FAIL ki_disp got %b want 0001111", disp6);
    end
    send_frame(8'h1C, 8'h80);
    repeat (20) pulse_clk_b();
    send_frame(8'hE4, 8'h80);
    repeat (2) pulse_clk_b();
    arm(1'b1);
    tick(700, d1, d2, d3);
    checks++;
    if ({d1, d2, d3} !== {32'd0, 32'd343, 32'd343}) begin
      failures++;
      $display("FAIL integ_sat got %0d/%0d/%0d want 0/343/343", d1, d2, d3);
    end
    checks++;
    if ({m2_dir_out, m3_dir_out} !== 2'b10) begin
      failures++;
      $display("FAIL integ_dir got %b%b want 10", m2_dir_out, m3_dir_out);
    end
    arm(1'b0);
    press_key(3);
    set_gains(3'd0, 3'd0, 3'd0);
    pulse_clk_b();
    arm(1'b1);
    tick(760, d1, d2, d3);
    checks++;
    if ({d1, d2, d3, m2_dir_out, m3_dir_out} !== {32'd0, 32'd371, 32'd371, 2'b01}) begin
      failures++;
      $display("FAIL integ_clear got %0d/%0d/%0d dir %b%b want 0/371/371 dir 01", d1, d2, d3,
               m2_dir_out, m3_dir_out);
    end
  endtask

  // u_x = -100 gives T2 = -87, T3 = 87; reset lands with both steps high.
  task automatic test_reset_mid_run();
    int d1, d2, d3;
    set_gains(3'd1, 3'd0, 3'd0);
    pulse_clk_b();
    tick(3, d1, d2, d3);
    checks++;
    if ({m2_step_out, m2_dir_out, m3_step_out, m3_dir_out} !== 4'b1011) begin
      failures++;
      $display("FAIL midrun_move got %b%b%b%b want 1011", m2_step_out, m2_dir_out, m3_step_out,
               m3_dir_out);
    end
    pixy_in = 1'b0;
    wait_cyc(Cpb);
    pixy_in = 1'b1;
    wait_cyc(Cpb);
    pixy_in = 1'b0;
    wait_cyc(Cpb);
    reset = 1'b1;
    pixy_in = 1'b1;
    wait_cyc(3);
    checks++;
    if ({m1_step_out, m2_step_out, m3_step_out, m1_dir_out, m2_dir_out, m3_dir_out,
         disp1, disp2, disp3, disp4} !== {6'b0, disp_ref(8'h80, 8'h80)}) begin
      failures++;
      $display("FAIL midrun_reset got %b%b%b%b%b%b %b", m1_step_out, m2_step_out, m3_step_out,
               m1_dir_out, m2_dir_out, m3_dir_out, {disp1, disp2, disp3, disp4});
    end
    reset = 1'b0;
    wait_cyc(4 * Cpb);
    send_frame(8'h70, 8'h80);
    checks++;
    if ({disp1, disp2, disp3, disp4} !== disp_ref(8'h70, 8'h80)) begin
      failures++;
      $display("FAIL midrun_frame got %b want %b", {disp1, disp2, disp3, disp4},
               disp_ref(8'h70, 8'h80));
    end
  endtask

  initial begin
    test_reset(3'd5, 3'd3);
    test_uart_frame();
    test_keys_view();
    test_reset(3'd2, 3'd6);
    test_proportional();
    test_stepping();
    test_disarm();
    test_integrator();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_for_diagram.md
# cpu_for_diagram

Top-level control core of the PID ball balancer. It receives ball-position frames from the Pixy camera over a UART line and runs one PID loop per axis (X, Y) on each sample strobe. It mixes the two axis outputs onto three 120°-spaced stepper motors, drives step/direction pins, and shows position and gains on six seven-segment displays. Gains come from board switches; keys set the setpoint, select the display view and clear the integrators.

## Interface
- CLKS_PER_BIT, 434, UART bit period in `clk` cycles (50 MHz / 115200).
- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clk_en  in  1  motor step-rate enable, one `clk` cycle wide, synchronous to `clk`.
- clk_b  in  1  PID sample strobe. It is an ordinary data input, not a clock: double-flop synchronized, rising-edge detected.
- pixy_in  in  1  UART RX (8N1, idle high) carrying camera frames.
- arduino_in  in  1  arm input, double-flop synchronized; high = motors may step.
- sw1..sw9  in  1 each  gains: Kp = {sw3,sw2,sw1}, Ki = {sw6,sw5,sw4}, Kd = {sw9,sw8,sw7}, unsigned 0–7.
- key_1, key_2, key_3  in  1 each  active-low pushbuttons, double-flop synchronized.
- m1_step_out, m2_step_out, m3_step_out  out  1 each  step pulses.
- m1_dir_out, m2_dir_out, m3_dir_out  out  1 each  direction; 1 = positive.
- Disp1..Disp6  out  7 each, indexed [0:6]  active-low segments, bit 0 = a … bit 6 = g.

## Operation
- **UART receiver:** start-bit detection and mid-bit sampling; bytes with a bad stop bit are dropped.
- **Frame parser:** a frame is three bytes: sync 0xA5, X, Y (unsigned 0–255).
  - X and Y are committed together to `pos_x`/`pos_y` on the Y stop bit.
  - A non-0xA5 byte while waiting for sync is ignored.
  - Any dropped byte restarts the parser at sync.
- **Keys:**
  - key_1 falling edge: setpoint ← current position.
  - key_2 held low: Disp1–4 show the setpoint instead of the position.
  - key_3 falling edge: both integrators ← 0.
- **PID (per axis, on each synchronized clk_b rising edge):**
  - e = setpoint − pos, signed 9-bit.
  - I ← clamp(I + Ki·e, −8191, +8191).
  - u = clamp(Kp·e + (I >>> 4) + Kd·(e − e_prev), −511, +511).
  - e_prev ← e.
  - All intermediates are at least 16-bit signed; >>> is arithmetic shift.
- **Mixing:** c = u_x − (u_x >>> 3), approximating 0.866·u_x.
  - T1 = u_y
  - T2 = −(u_y >>> 1) + c
  - T3 = −(u_y >>> 1) − c
  - Targets are 11-bit signed; no overflow is possible.
- **Step generator (per motor):** 11-bit signed position counter P. On each clk_en cycle with arduino_in high and P ≠ T:
  - if step = 0: dir ← (T > P), step ← 1;
  - else: step ← 0, P ← P ± 1 according to dir.
  - One full step spans 2 clk_en ticks.
  - With arduino_in low or P = T: step ← 0 on the next clk_en; dir and P hold.
  - A target change mid-pulse takes effect at the next step rise.
- **Displays:** hex digits.
  - Disp1 = X[7:4], Disp2 = X[3:0], Disp3 = Y[7:4], Disp4 = Y[3:0], taken from position or setpoint per key_2.
  - Disp5 = Kp, Disp6 = Ki.
  - Segment codes: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.

## Timing
- **Reset values:**
  - pos = setpoint = (0x80, 0x80); I, e_prev, u, targets and P all 0.
  - All step and dir outputs 0.
  - Disp1–4 = "8080" (0000000/0000001); Disp5/6 reflect the live switches combinationally through the decoder.
- **Reset mid-operation:** any in-flight UART byte is abandoned and the parser returns to sync.
- **Input synchronizers:** clk_b, key_* and arduino_in are each delayed by 2 cycles.
- **PID latency:** u is registered on the cycle after the detected clk_b edge; targets follow 1 cycle later.
- **Same-cycle frame commit and PID edge:** the PID uses the old position.
- **Step pins:** step and dir change only on cycles with clk_en = 1; dir is stable whenever step rises.
- **Display latency:** displays update 1 cycle after the position or setpoint register changes.

## Test plan
- **Reset:** pulse reset high mid-run → all step/dir = 0, Disp1–4 = 0000000,0000001,0000000,0000001.
- **UART frame:** send A5,40,C0 on pixy_in → Disp1–4 show 4,0,C,0 (1001100,0000001,0110001,0000001).
- **Proportional only:** Kp = 1, Ki = Kd = 0, pos = (0x70,0x80), one clk_b edge → u_x = 16, u_y = 0; T1 = 0, T2 = 14, T3 = −14.
- **Stepping:** arduino_in = 1, T2 = 14 → exactly 14 m2 step rises over 28 clk_en ticks, m2_dir = 1, then idle. m3 gives 14 steps with dir = 0.
- **Disarm:** arduino_in = 0 mid-move → no further step rises, P holds; re-arm → stepping resumes to target.
- **Integrator:** Ki = 7, e = 100, repeated clk_b edges → I saturates at 8191; a key_3 press → I = 0.
